// File: rtl/max3421e_reg_seq.sv
// max3421e_reg_seq: one MAX3421E register read/write per command,
// sequenced over the SPI core register port. Macro: SPI_SEQ_TIMEOUT_EN.
module max3421e_reg_seq #(
    parameter logic [15:0] SLAVE_MASK     = 16'h0001,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [7:0]  rsp_status,
    output logic        rsp_error,
    output logic        spi_select,
    output logic [2:0]  spi_addr,
    output logic        spi_read_n,
    output logic        spi_write_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata
);

    typedef enum logic [3:0] {
        IDLE, CLR, SEL, SSON,
        PT1, TXC, PR1, RXS,
        PT2, TXD, PR2, RXD,
        PTMT, SSOFF, DONE
    } state_t;

    localparam logic [2:0] A_RX   = 3'd0;
    localparam logic [2:0] A_TX   = 3'd1;
    localparam logic [2:0] A_STAT = 3'd2;
    localparam logic [2:0] A_CTRL = 3'd3;
    localparam logic [2:0] A_SLV  = 3'd5;

    state_t     state;
    state_t     state_n;
    logic [1:0] ph;
    logic [1:0] ph_n;
    logic [7:0] cmd_byte;
    logic [7:0] tx_byte;
    logic       hit;
    logic       poll_bit;
    logic       accept;
    logic       busy;
    logic       gap;
    logic       is_poll;
    logic       is_read;
    logic       tmo;
    logic       tmo_take;
    logic       unused_hi;

    assign accept    = (state == IDLE) && cmd_valid;
    assign busy      = (state != IDLE) && (state != DONE);
    assign gap       = (ph == 2'd2);
    assign is_poll   = state inside {PT1, PT2, PR1, PR2, PTMT};
    assign is_read   = is_poll || (state == RXS) || (state == RXD);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign unused_hi = ^spi_rdata[15:8];

    function automatic state_t seq_next(input state_t s);
        unique case (s)
            CLR:     return SEL;
            SEL:     return SSON;
            SSON:    return PT1;
            PT1:     return TXC;
            TXC:     return PR1;
            PR1:     return RXS;
            RXS:     return PT2;
            PT2:     return TXD;
            TXD:     return PR2;
            PR2:     return RXD;
            RXD:     return PTMT;
            PTMT:    return SSOFF;
            SSOFF:   return DONE;
            default: return IDLE;
        endcase
    endfunction

    // status bit that releases the current poll state
    always_comb begin
        poll_bit = 1'b0;
        unique case (state)
            PT1, PT2: poll_bit = spi_rdata[6];
            PR1, PR2: poll_bit = spi_rdata[7];
            PTMT:     poll_bit = spi_rdata[5];
            default:  poll_bit = 1'b0;
        endcase
    end

    // next state: each access is 2 select cycles plus 1 gap cycle
    always_comb begin
        state_n  = state;
        ph_n     = ph;
        tmo_take = 1'b0;
        if (state == IDLE) begin
            if (cmd_valid) begin
                state_n = CLR;
                ph_n    = 2'd0;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (!gap) begin
            ph_n = ph + 2'd1;
        end else begin
            ph_n = 2'd0;
            if (is_poll && !hit) begin
                if (tmo) begin
                    state_n  = SSOFF;
                    tmo_take = 1'b1;
                end
            end else begin
                state_n = seq_next(state);
            end
        end
    end

    // state and access phase registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ph    <= 2'd0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
        end
    end

    // command capture, poll result and response bytes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_byte   <= 8'h00;
            tx_byte    <= 8'h00;
            hit        <= 1'b0;
            rsp_rdata  <= 8'h00;
            rsp_status <= 8'h00;
        end else begin
            if (accept) begin
                cmd_byte <= {cmd_reg, 1'b0, cmd_write, 1'b0};
                tx_byte  <= cmd_write ? cmd_wdata : 8'h00;
            end
            if (ph == 2'd1) begin
                if (is_poll) begin
                    hit <= poll_bit;
                end
                if (state == RXS) begin
                    rsp_status <= spi_rdata[7:0];
                end
                if (state == RXD) begin
                    rsp_rdata <= spi_rdata[7:0];
                end
            end
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err;

    assign tmo       = is_poll && (int'(tmo_cnt) >= TIMEOUT_CYCLES - 1);
    assign rsp_error = err;

    // cycles spent in the current poll state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= 16'h0000;
        end else if (state_n != state) begin
            tmo_cnt <= 16'h0000;
        end else if (is_poll && (tmo_cnt != 16'hFFFF)) begin
            tmo_cnt <= tmo_cnt + 16'h0001;
        end
    end

    // sticky error flag until the next command is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (tmo_take) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign rsp_error  = 1'b0;
    assign unused_tmo = ^{tmo_take, 32'(TIMEOUT_CYCLES)};
`endif

    // register-port drive: quiet during gap, IDLE and DONE
    always_comb begin
        spi_select  = 1'b0;
        spi_read_n  = 1'b1;
        spi_write_n = 1'b1;
        spi_addr    = 3'd0;
        spi_wdata   = 16'h0000;
        if (busy && !gap) begin
            spi_select  = 1'b1;
            spi_read_n  = !is_read;
            spi_write_n = is_read;
            unique case (state)
                CLR: begin
                    spi_addr = A_STAT;
                end
                SEL: begin
                    spi_addr  = A_SLV;
                    spi_wdata = SLAVE_MASK;
                end
                SSON: begin
                    spi_addr  = A_CTRL;
                    spi_wdata = 16'h0400;
                end
                TXC: begin
                    spi_addr  = A_TX;
                    spi_wdata = {8'h00, cmd_byte};
                end
                TXD: begin
                    spi_addr  = A_TX;
                    spi_wdata = {8'h00, tx_byte};
                end
                RXS, RXD: begin
                    spi_addr = A_RX;
                end
                SSOFF: begin
                    spi_addr = A_CTRL;
                end
                default: begin
                    spi_addr = A_STAT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max3421e_reg_seq.sv
// tb_max3421e_reg_seq: directed bench with a small SPI core model.
// Optional timeout scenario when SPI_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_max3421e_reg_seq;

    localparam int BYTE_T = 20;
    localparam int BUDGET = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_reg = 5'd0;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [7:0]  rsp_status;
    logic        rsp_error;
    logic        spi_select;
    logic [2:0]  spi_addr;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [15:0] spi_wdata;
    logic [15:0] spi_rdata;

    always #10 clk = ~clk;

    max3421e_reg_seq #(
        .SLAVE_MASK(16'h0001),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_reg(cmd_reg),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status),
        .rsp_error(rsp_error),
        .spi_select(spi_select),
        .spi_addr(spi_addr),
        .spi_read_n(spi_read_n),
        .spi_write_n(spi_write_n),
        .spi_wdata(spi_wdata),
        .spi_rdata(spi_rdata)
    );

    // SPI core model state
    logic [7:0]  miso0 = 8'h00;
    logic [7:0]  miso1 = 8'h00;
    logic        force_zero = 1'b0;
    logic        m_rrdy, m_trdy, m_tmt, m_roe;
    logic        m_busy, m_sso, m_wr_prev;
    logic [7:0]  m_rxbuf, m_rxnext;
    logic [15:0] m_slv;
    logic [15:0] m_stat;
    int          m_cnt, m_pbytes;
    int          n_bytes = 0;
    int          outside = 0;
    int          reon = 0;
    int          ss_offs = 0;
    int          last_bytes = 0;
    logic [7:0]  mosi_log [0:63];

    assign m_stat = force_zero ? 16'h0000 :
        {8'h00, m_rrdy, m_trdy, m_tmt, 1'b0, m_roe, 3'b000};

    // register port of the SPI core with a fixed byte time
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rrdy    <= 1'b0;
            m_trdy    <= 1'b1;
            m_tmt     <= 1'b1;
            m_roe     <= 1'b0;
            m_busy    <= 1'b0;
            m_sso     <= 1'b0;
            m_wr_prev <= 1'b0;
            m_rxbuf   <= 8'h00;
            m_rxnext  <= 8'h00;
            m_slv     <= 16'h0000;
            m_cnt     <= 0;
            m_pbytes  <= 0;
            spi_rdata <= 16'h0000;
        end else begin
            m_wr_prev <= spi_select && !spi_write_n;
            case (spi_addr)
                3'd0:    spi_rdata <= {8'h00, m_rxbuf};
                3'd2:    spi_rdata <= m_stat;
                3'd3:    spi_rdata <= {5'b0, m_sso, 10'b0};
                3'd5:    spi_rdata <= m_slv;
                default: spi_rdata <= 16'h0000;
            endcase
            if (spi_select && !spi_read_n && spi_addr == 3'd0)
                m_rrdy <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    m_trdy  <= 1'b1;
                    m_tmt   <= 1'b1;
                    m_rxbuf <= m_rxnext;
                    m_rrdy  <= 1'b1;
                    if (m_rrdy) m_roe <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (spi_select && !spi_write_n && !m_wr_prev) begin
                case (spi_addr)
                    3'd1: begin
                        m_busy   <= 1'b1;
                        m_cnt    <= BYTE_T;
                        m_trdy   <= 1'b0;
                        m_tmt    <= 1'b0;
                        m_rxnext <= (m_pbytes == 0) ? miso0 : miso1;
                        m_pbytes <= m_pbytes + 1;
                        mosi_log[n_bytes[5:0]] <= spi_wdata[7:0];
                        n_bytes  <= n_bytes + 1;
                        if (!(m_sso && m_slv != 16'h0000))
                            outside <= outside + 1;
                    end
                    3'd2: begin
                        m_rrdy <= 1'b0;
                        m_roe  <= 1'b0;
                    end
                    3'd3: begin
                        if (spi_wdata[10]) begin
                            if (m_sso) reon <= reon + 1;
                            m_sso    <= 1'b1;
                            m_pbytes <= 0;
                        end else begin
                            if (m_sso) begin
                                last_bytes <= m_pbytes;
                                ss_offs    <= ss_offs + 1;
                            end
                            m_sso <= 1'b0;
                        end
                    end
                    3'd5: m_slv <= spi_wdata;
                    default: ;
                endcase
            end
        end
    end

    int          ncmp = 0;
    int          nfail = 0;
    logic        prev_sel = 1'b0;
    int          run = 0;
    logic [2:0]  p_addr = 3'd0;
    logic [15:0] p_wdata = 16'h0000;
    logic [1:0]  p_strb = 2'b11;
    int          base, n, acc, rsp, k, offs0, nready;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; bus protocol checked on every cycle
    task automatic tick();
        @(negedge clk);
        if (!reset_n) begin
            prev_sel = 1'b0;
            run      = 0;
        end else begin
            chk("strobe_excl", {31'd0, spi_read_n | spi_write_n}, 1);
            if (!spi_select) begin
                chk("idle_strobes", {30'd0, spi_read_n, spi_write_n}, 3);
                if (prev_sel) chk("sel_len", run, 2);
                run = 0;
            end else begin
                if (prev_sel) begin
                    chk("hold_addr", {29'd0, spi_addr}, {29'd0, p_addr});
                    chk("hold_wdata", {16'd0, spi_wdata}, {16'd0, p_wdata});
                    chk("hold_strb", {30'd0, spi_read_n, spi_write_n},
                        {30'd0, p_strb});
                end
                run++;
                chk("sel_max", {31'd0, run <= 2}, 1);
                chk("strobe_act", {31'd0, spi_read_n ^ spi_write_n}, 1);
                if (!spi_write_n && spi_addr == 3'd5)
                    chk("slv_mask", {16'd0, spi_wdata}, 32'h0001);
                if (!spi_write_n && spi_addr == 3'd1)
                    chk("tx_hi", {24'd0, spi_wdata[15:8]}, 0);
            end
            prev_sel = spi_select;
            p_addr   = spi_addr;
            p_wdata  = spi_wdata;
            p_strb   = {spi_read_n, spi_write_n};
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 0);
        chk("rst_status", {24'd0, rsp_status}, 0);
        chk("rst_error", {31'd0, rsp_error}, 0);
        chk("rst_select", {31'd0, spi_select}, 0);
        chk("rst_read_n", {31'd0, spi_read_n}, 1);
        chk("rst_write_n", {31'd0, spi_write_n}, 1);
        chk("rst_addr", {29'd0, spi_addr}, 0);
        chk("rst_wdata", {16'd0, spi_wdata}, 0);
    endtask

    // issue one command and wait for its single response pulse
    task automatic run_cmd(input logic w, input logic [4:0] r,
                           input logic [7:0] d, input logic [7:0] s0,
                           input logic [7:0] s1);
        int cyc;
        int rdy;
        miso0     = s0;
        miso1     = s1;
        cmd_write = w;
        cmd_reg   = r;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("acc_ready_low", {31'd0, cmd_ready}, 0);
        chk("first_access", {31'd0, spi_select}, 1);
        cyc = 0;
        rdy = 0;
        while (!rsp_valid && cyc < BUDGET) begin
            tick();
            cyc++;
            if (cmd_ready) rdy++;
        end
        chk("rsp_seen", {31'd0, rsp_valid}, 1);
        chk("busy_ready_low", rdy, 0);
        tick();
        chk("rsp_pulse", {31'd0, rsp_valid}, 0);
        chk("ready_back", {31'd0, cmd_ready}, 1);
    endtask

    initial begin
        tick();
        tick();
        chk_reset_vals();
        reset_n = 1'b1;
        tick();
        tick();

        base = n_bytes;
        run_cmd(1'b1, 5'd17, 8'hA5, 8'h3C, 8'h00);
        chk("wr_nbytes", n_bytes - base, 2);
        chk("wr_mosi0", {24'd0, mosi_log[base]}, 32'h8A);
        chk("wr_mosi1", {24'd0, mosi_log[base + 1]}, 32'hA5);
        chk("wr_status", {24'd0, rsp_status}, 32'h3C);
        chk("wr_rdata", {24'd0, rsp_rdata}, 32'h00);
        chk("wr_ss_bytes", last_bytes, 2);
        chk("wr_outside", outside, 0);

        base = n_bytes;
        run_cmd(1'b0, 5'd19, 8'hEE, 8'h81, 8'h5A);
        chk("rd_nbytes", n_bytes - base, 2);
        chk("rd_mosi0", {24'd0, mosi_log[base]}, 32'h98);
        chk("rd_mosi1", {24'd0, mosi_log[base + 1]}, 32'h00);
        chk("rd_rdata", {24'd0, rsp_rdata}, 32'h5A);
        chk("rd_status", {24'd0, rsp_status}, 32'h81);

        offs0     = ss_offs;
        miso0     = 8'h12;
        miso1     = 8'h34;
        cmd_write = 1'b0;
        cmd_reg   = 5'd3;
        cmd_valid = 1'b1;
        acc       = 0;
        rsp       = 0;
        nready    = 0;
        n         = 0;
        while (rsp < 3 && n < 3 * BUDGET) begin
            if (cmd_valid) begin
                if (cmd_ready) begin
                    acc++;
                    nready++;
                end else if (acc == 3) begin
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_valid) rsp++;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_rsp", rsp, 3);
        chk("b2b_acc", acc, 3);
        chk("b2b_ready_cycles", nready, 3);
        for (int i = 0; i < 40; i++) tick();
        chk("b2b_ss_periods", ss_offs - offs0, 3);
        chk("b2b_reon", reon, 0);
        chk("b2b_outside", outside, 0);
        chk("b2b_idle", {31'd0, cmd_ready}, 1);

        miso0     = 8'h11;
        miso1     = 8'h22;
        cmd_write = 1'b0;
        cmd_reg   = 5'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(m_busy && spi_select && !spi_read_n && spi_addr == 3'd2)
               && n < BUDGET) begin
            tick();
            n++;
        end
        chk("pr1_found", {31'd0, m_busy && spi_select}, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        base = n_bytes;
        run_cmd(1'b0, 5'd0, 8'h00, 8'h42, 8'h99);
        chk("rr_nbytes", n_bytes - base, 2);
        chk("rr_mosi0", {24'd0, mosi_log[base]}, 32'h00);
        chk("rr_mosi1", {24'd0, mosi_log[base + 1]}, 32'h00);
        chk("rr_rdata", {24'd0, rsp_rdata}, 32'h99);
        chk("rr_status", {24'd0, rsp_status}, 32'h42);
        chk("rr_error", {31'd0, rsp_error}, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
        offs0      = ss_offs;
        force_zero = 1'b1;
        cmd_write  = 1'b1;
        cmd_reg    = 5'd1;
        cmd_wdata  = 8'h77;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(m_sso && spi_select && !spi_read_n && spi_addr == 3'd2)
               && n < 100) begin
            tick();
            n++;
        end
        chk("pt1_found", {31'd0, m_sso && spi_select}, 1);
        k = 0;
        while (!rsp_valid && k < 76) begin
            tick();
            k++;
        end
        chk("tmo_window", {31'd0, rsp_valid}, 1);
        chk("tmo_error", {31'd0, rsp_error}, 1);
        chk("tmo_status_kept", {24'd0, rsp_status}, 32'h42);
        chk("tmo_rdata_kept", {24'd0, rsp_rdata}, 32'h99);
        chk("tmo_ssoff", ss_offs - offs0, 1);
        chk("tmo_ss_released", {31'd0, m_sso}, 0);
        tick();
        force_zero = 1'b0;
        run_cmd(1'b0, 5'd2, 8'h00, 8'h10, 8'h20);
        chk("tmo_err_clear", {31'd0, rsp_error}, 0);
        chk("tmo_next_rdata", {24'd0, rsp_rdata}, 32'h20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
